// File: rtl/otter_pkg.sv
// Shared types for the iterative divider: operand width, opcode and FSM state encodings.
// Pure declarations plus two small opcode decoders; no timing of its own.
// No flow control; consumers decide how to use the decoded opcode.
package otter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

    // Signed variants work on magnitudes and need a sign fix afterwards.
    function automatic logic op_is_signed(input div_op_t o);
        return (o == DIV) || (o == REM);
    endfunction

    // Remainder variants return the partial remainder instead of the quotient.
    function automatic logic op_is_rem(input div_op_t o);
        return (o == REM) || (o == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
// Purely combinational, zero cycles.
// No flow control; the caller registers the outputs once per cycle.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    // The partial remainder is always below the divisor, so after the shift it can need
    // one extra bit; the compare uses the full width, while a successful subtract always
    // lands back inside XLEN bits, so the low bits alone are enough for the difference.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, i_div});
    assign w_sub   = w_shift[XLEN-1:0] - i_div;
    assign o_rem   = w_ge ? w_sub : w_shift[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// RV32M-style divider (DIV/DIVU/REM/REMU): 32-cycle restoring core, then a sign-fix cycle.
// Latency: start edge -> done in cycle 34 (cycle 1 for /0 and overflow when DIV_FASTPATH_EN is defined).
// Single-outstanding: start is ignored while busy (including the DONE cycle); nothing is queued.
module div_unit #(
    parameter int XLEN = otter_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wa,
    output logic            we
);

    import otter_pkg::*;

    div_state_t      r_state;
    div_op_t         r_op;
    logic [4:0]      r_cnt;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_a;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_bzero;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_wa;
    logic            r_done;
    logic            r_we;

    div_op_t         w_op;
    logic            w_signed;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_fix_res;

    assign w_op     = div_op_t'(op);
    assign w_signed = op_is_signed(w_op);
    assign w_a_mag  = (w_signed && a[XLEN-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[XLEN-1]) ? -b : b;

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // Divide-by-zero leaves an all-ones quotient and the magnitude as remainder, which the sign
    // fix would corrupt for negative dividends, so it is overridden here. Signed overflow needs no
    // special case: |MIN|/1 = 0x80000000 and negating it wraps back to 0x80000000 with remainder 0.
    assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
    assign w_fix_res = r_bzero ? (op_is_rem(r_op) ? r_a : '1)
                               : (op_is_rem(r_op) ? w_r_fix : w_q_fix);

`ifdef DIV_FASTPATH_EN
    logic            w_fast;
    logic            w_ovf;
    logic [XLEN-1:0] w_fast_res;

    assign w_ovf      = w_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_fast     = (b == '0) || w_ovf;
    assign w_fast_res = (b == '0) ? (op_is_rem(w_op) ? a : '1)
                                  : (op_is_rem(w_op) ? '0 : a);
`endif

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign we     = r_we;
    assign wa     = r_wa;
    assign result = r_result;

    // Control FSM with registered outputs: latch operands, iterate, fix signs, pulse done for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= DIV;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_a      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_result <= '0;
            r_wa     <= '0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_we   <= 1'b0;
                    if (start) begin
                        r_op    <= w_op;
                        r_rd    <= rd_in;
                        r_a     <= a;
                        r_div   <= w_b_mag;
                        r_quo   <= w_a_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        r_neg_r <= w_signed && a[XLEN-1];
                        r_bzero <= (b == '0);
`ifdef DIV_FASTPATH_EN
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_wa     <= rd_in;
                            r_we     <= (rd_in != 5'd0);
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= CALC;
                        end
`else
                        r_state <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_result <= w_fix_res;
                    r_wa     <= r_rd;
                    r_we     <= (r_rd != 5'd0);
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operations against an arithmetic model.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Exercises start-while-busy, start during DONE, back-to-back starts and reset mid-operation.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wa;
    logic        we;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] K_DIV = 2'b00, K_DIVU = 2'b01, K_REM = 2'b10, K_REMU = 2'b11;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wa     (wa),
        .we     (we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_signed_op(input logic [1:0] o);
        return (o == K_DIV) || (o == K_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] o);
        return (o == K_REM) || (o == K_REMU);
    endfunction

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return (y == 32'd0) || (is_signed_op(o) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics written directly with the language's division operators.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return is_rem_op(o) ? x : 32'hFFFF_FFFF;
        if (is_signed_op(o)) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return is_rem_op(o) ? 32'd0 : 32'h8000_0000;
            return is_rem_op(o) ? sx % sy : sx / sy;
        end
        return is_rem_op(o) ? x % y : x / y;
    endfunction

    function automatic int model_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_FASTPATH_EN
        if (is_special(o, x, y)) return 1;
`endif
        return 34;
    endfunction

    // Issue one operation from an IDLE cycle and follow it to completion. A nonzero intr_cyc
    // re-asserts start with other operands during that busy cycle. Returns in the next IDLE cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] rd, input int intr_cyc);
        logic [31:0] exp_res;
        int          exp_lat;
        int          cyc;
        exp_res = model(o, x, y);
        exp_lat = model_latency(o, x, y);
        start = 1'b1; op = o; a = x; b = y; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; rd_in = 5'($urandom);
        cyc = 1;
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        while (!done && cyc < 60) begin
            start = (cyc == intr_cyc);
            if (cyc == intr_cyc) begin
                op = 2'($urandom); a = $urandom; b = $urandom_range(1, 1000); rd_in = 5'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done"},    32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_result"},  result, exp_res);
        check({tag, "_we"},      32'(we), 32'(rd != 5'd0));
        check({tag, "_wa"},      32'(wa), 32'(rd));
        // A start raised during the DONE cycle must be dropped.
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom_range(1, 1000); rd_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_post_done"}, 32'(done), 32'd0);
        check({tag, "_post_we"},   32'(we), 32'd0);
        check({tag, "_post_busy"}, 32'(busy), 32'd0);
        check({tag, "_post_hold"}, result, exp_res);
    endtask

    initial begin
        logic        bad;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_we",     32'(we), 32'd0);
        check("rst_wa",     32'(wa), 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op("divu_100_7",   K_DIVU, 32'd100, 32'd7, 5'd5, 0);
        run_op("remu_100_7",   K_REMU, 32'd100, 32'd7, 5'd5, 0);
        run_op("div_m7_2",     K_DIV,  32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        run_op("rem_m7_2",     K_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, 0);
        run_op("div_5_0",      K_DIV,  32'd5, 32'd0, 5'd8, 0);
        run_op("remu_5_0",     K_REMU, 32'd5, 32'd0, 5'd8, 0);
        run_op("rem_m5_0",     K_REM,  32'hFFFF_FFFB, 32'd0, 5'd3, 0);
        run_op("div_ovf",      K_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run_op("rem_ovf",      K_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        run_op("divu_ovfpat",  K_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
        run_op("div_intr5",    K_DIV,  32'd1000, 32'hFFFF_FFFD, 5'd13, 5);
        run_op("divu_rd0",     K_DIVU, 32'd77, 32'd3, 5'd0, 0);

        // Reset during CALC aborts with no write, even after release
        start = 1'b1; op = K_DIVU; a = 32'd12345; b = 32'd67; rd_in = 5'd21;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_done",   32'(done), 32'd0);
        check("abort_we",     32'(we), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_wa",     32'(wa), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || we || busy) bad = 1'b1;
        end
        check("abort_quiet", 32'(bad), 32'd0);
        run_op("after_abort", K_REMU, 32'd12345, 32'd67, 5'd21, 0);

        // Random operations, biased toward small, zero and all-ones divisors
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
                3:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb, 5'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width (only 32 is supported).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The block SHALL have ports a and b, input, XLEN bits each: dividend (register-file rs1) and divisor (register-file rs2).
REQ-007 The block SHALL have port rd_in, input, 5 bits: destination register index.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have ports result (output, XLEN bits), wa (output, 5 bits) and we (output, 1 bit): these drive register-file wd, wa and en.

Function
REQ-011 The state machine SHALL have states IDLE, CALC, FIX and DONE.
REQ-012 In IDLE, start=1 SHALL latch a, b, op and rd_in at the clock edge and move to CALC; inputs are ignored after that edge.
REQ-013 CALC SHALL run exactly 32 restoring-division iterations, one per cycle, on operand magnitudes (absolute values for DIV/REM, raw values for DIVU/REMU).
REQ-014 FIX SHALL apply sign correction: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
REQ-015 DONE SHALL last exactly one cycle with done=1, we=(latched rd!=0), result valid and wa=latched rd; the next state is IDLE.
REQ-016 Latency: start sampled at edge 0 -> CALC in cycles 1-32, FIX in cycle 33, done in cycle 34.
REQ-017 Divide by zero SHALL give DIV/DIVU result 0xFFFFFFFF and REM/REMU result equal to a.
REQ-018 Signed overflow (a=0x80000000, b=0xFFFFFFFF) SHALL give DIV result 0x80000000 and REM result 0.
REQ-019 start asserted while busy=1 (including the DONE cycle) SHALL be ignored, with no queueing.
REQ-020 Outside DONE, done=0, we=0 and result SHALL hold its last value.
REQ-021 Back-to-back operation: start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, we=0, wa=0, result=0, and clear all internal registers.
REQ-023 Reset during CALC, FIX or DONE SHALL abort the operation with no write pulse, including after rst deasserts.

Configuration
REQ-024 Macro DIV_FASTPATH_EN SHALL control a fast path for divide-by-zero and signed overflow.
REQ-025 With DIV_FASTPATH_EN defined, these two cases SHALL go IDLE->DONE directly, with done at cycle 1 after the start edge.
REQ-026 Without DIV_FASTPATH_EN, these two cases SHALL take the full 34-cycle path and still produce the REQ-017/018 values.

Structure
REQ-027 Package otter_pkg SHALL hold XLEN, enum div_op_t (DIV, DIVU, REM, REMU) and enum div_state_t.
REQ-028 One combinational sub-module, div_step, SHALL perform a single shift/compare/subtract iteration; div_unit SHALL instantiate it once.

Verification
REQ-029 The bench SHALL cover: DIVU a=100 b=7 rd=5 -> cycle 34: done=1, we=1, wa=5, result=14; REMU same operands -> result=2.
REQ-030 The bench SHALL cover: DIV a=-7 (0xFFFFFFF9) b=2 -> result 0xFFFFFFFD (-3); REM same operands -> result 0xFFFFFFFF (-1).
REQ-031 The bench SHALL cover: DIV a=5 b=0 -> 0xFFFFFFFF; REMU a=5 b=0 -> 5; done at cycle 1 with DIV_FASTPATH_EN, at cycle 34 without.
REQ-032 The bench SHALL cover: DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-033 The bench SHALL cover: rst pulsed at cycle 10 of CALC -> busy=0 immediately; no done/we for 40 following cycles; next op completes normally.
REQ-034 The bench SHALL cover: second start at cycle 5 with different operands -> ignored, first result unchanged; DIVU rd=0 -> done=1, we=0.
